// File: rtl/secded_pkg.sv
// -----------------------------------------------------------------------------
// secded_pkg
// Shared definitions for the pipelined SECDED corrector: check-bit count
// derivation, data-index to codeword-position mapping, the error class enum
// and a reference encoder producing Hamming + overall parity check bits.
//
// Code layout: codeword positions 1..DATA_W+R, Hamming bit i at position 2^i,
// data bits fill the remaining positions in ascending order (data[0] at 3),
// overall parity makes the XOR of every codeword bit even.
// -----------------------------------------------------------------------------
package secded_pkg;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_R      = 7;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_CORR   = 2'd1,
        ERR_UNCORR = 2'd2
    } err_e;

    // Smallest r with 2^r >= dw + r + 1 (descending scan keeps the smallest).
    function automatic int calc_r(input int dw);
        int r_v;
        r_v = MAX_R;
        for (int i = MAX_R; i >= 1; i--) begin
            if ((32'd1 << i) >= (dw + i + 1)) begin
                r_v = i;
            end
        end
        return r_v;
    endfunction

    // Codeword position of data bit k: the k-th non-power-of-two position.
    function automatic int data_pos(input int k);
        int pos_v;
        int cnt_v;
        pos_v = 0;
        cnt_v = 0;
        for (int p = 1; p <= MAX_DATA_W + MAX_R; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt_v == k) begin
                    pos_v = p;
                end
                cnt_v++;
            end
        end
        return pos_v;
    endfunction

    // Reference encoder: bits [r-1:0] Hamming, bit [r] overall parity,
    // bits above r are zero. Only data[dw-1:0] participate.
    function automatic logic [MAX_R:0] enc(input logic [MAX_DATA_W-1:0] data,
                                           input int                    dw);
        logic [MAX_R:0] chk_v;
        logic           par_v;
        int             r_v;
        int             pos_v;
        chk_v = '0;
        par_v = 1'b0;
        r_v   = calc_r(dw);
        for (int k = 0; k < MAX_DATA_W; k++) begin
            if ((k < dw) && data[k]) begin
                pos_v = data_pos(k);
                par_v = ~par_v;
                for (int i = 0; i < MAX_R; i++) begin
                    if ((i < r_v) && pos_v[i]) begin
                        chk_v[i] = ~chk_v[i];
                    end
                end
            end
        end
        chk_v[r_v] = par_v ^ (^chk_v);
        return chk_v;
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// -----------------------------------------------------------------------------
// secded_syndrome
// Combinational extended-Hamming decode of one received word.
//   data_i : received data bits
//   chk_i  : received check bits, [R-1:0] Hamming, [R] overall parity
//   syn_o  : XOR of the position indices of all set codeword bits
//   par_o  : XOR of every received bit (1 = odd number of flips)
// -----------------------------------------------------------------------------
module secded_syndrome
    import secded_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int R      = calc_r(DATA_W)
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [R:0]        chk_i,
    output logic [R-1:0]      syn_o,
    output logic              par_o
);

    logic [R-1:0] contrib_s [DATA_W];

    // Each set data bit contributes its (constant) codeword position.
    for (genvar k = 0; k < DATA_W; k++) begin : g_pos
        localparam logic [R-1:0] POS_V = R'(data_pos(k));
        assign contrib_s[k] = data_i[k] ? POS_V : '0;
    end

    // Fold data contributions onto the Hamming bits, which sit at 2^i.
    always_comb begin
        syn_o = chk_i[R-1:0];
        for (int k = 0; k < DATA_W; k++) begin
            syn_o = syn_o ^ contrib_s[k];
        end
    end

    assign par_o = (^data_i) ^ (^chk_i);

endmodule

// File: rtl/secded_pipe_corrector.sv
// -----------------------------------------------------------------------------
// secded_pipe_corrector
// Two-stage SECDED corrector on a valid/ready stream with error statistics.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : input handshake; in_data + in_chk (R+1 bits)
//   correct_en         : 1 = flip located data bit, 0 = detect only
//   out_valid/out_ready: output handshake; out_data, out_err, out_syn
//   cnt_clr            : clears counters and first-failure capture
//   cnt_corr/uncorr    : saturating counts of accepted err=1 / err=2 words
//   first_fail/syn     : sticky capture of the first uncorrectable word
// Stage 1 holds data, syndrome, parity and correct_en; stage 2 holds the
// corrected word and its class. The whole pipe moves when stage 2 is empty or
// being drained, so in_ready depends combinationally on out_ready.
// -----------------------------------------------------------------------------
module secded_pipe_corrector
    import secded_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int R      = calc_r(DATA_W),
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [R:0]        in_chk,
    input  logic              correct_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_err,
    output logic [R-1:0]      out_syn,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr,
    output logic              first_fail,
    output logic [R-1:0]      first_syn
);

    localparam logic [R-1:0]     LAST_POS = R'(DATA_W + R);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Handshake
    logic advance_s;
    logic out_fire_s;

    // Syndrome of the incoming word
    logic [R-1:0] in_syn_s;
    logic         in_par_s;

    // Stage 1
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q,  s1_data_d;
    logic [R-1:0]      s1_syn_q,   s1_syn_d;
    logic              s1_par_q,   s1_par_d;
    logic              s1_ce_q,    s1_ce_d;

    // Classification of stage 1 contents
    logic [DATA_W-1:0] flip_mask_s;
    logic [DATA_W-1:0] corr_data_s;
    err_e              cls_err_s;

    // Stage 2
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    err_e              out_err_q,   out_err_d;
    logic [R-1:0]      out_syn_q,   out_syn_d;

    // Statistics
    logic [CNT_W-1:0]  cnt_corr_q,   cnt_corr_d;
    logic [CNT_W-1:0]  cnt_uncorr_q, cnt_uncorr_d;
    logic              first_fail_q, first_fail_d;
    logic [R-1:0]      first_syn_q,  first_syn_d;

    assign advance_s  = ~out_valid_q | out_ready;
    assign out_fire_s = out_valid_q & out_ready;

    secded_syndrome #(
        .DATA_W (DATA_W),
        .R      (R)
    ) u_syndrome (
        .data_i (in_data),
        .chk_i  (in_chk),
        .syn_o  (in_syn_s),
        .par_o  (in_par_s)
    );

    // One-hot data bit located by the syndrome; never matches a check position.
    for (genvar k = 0; k < DATA_W; k++) begin : g_flip
        localparam logic [R-1:0] POS_V = R'(data_pos(k));
        assign flip_mask_s[k] = (s1_syn_q == POS_V);
    end

    // Stage 1 next state: capture a new word or a bubble when the pipe moves.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        s1_ce_d    = s1_ce_q;
        if (advance_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_syn_d  = in_syn_s;
                s1_par_d  = in_par_s;
                s1_ce_d   = correct_en;
            end else begin
                s1_data_d = s1_data_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Classify the stage 1 word and build its corrected data.
    always_comb begin
        cls_err_s   = ERR_NONE;
        corr_data_s = s1_data_q;
        if (s1_par_q) begin
            if (s1_syn_q == '0) begin
                // Only the overall parity bit flipped.
                cls_err_s = ERR_CORR;
            end else if (s1_syn_q <= LAST_POS) begin
                cls_err_s = ERR_CORR;
                if (s1_ce_q) begin
                    corr_data_s = s1_data_q ^ flip_mask_s;
                end else begin
                    corr_data_s = s1_data_q;
                end
            end else begin
                // Odd flip count pointing outside the codeword.
                cls_err_s = ERR_UNCORR;
            end
        end else if (s1_syn_q != '0) begin
            cls_err_s = ERR_UNCORR;
        end else begin
            cls_err_s = ERR_NONE;
        end
    end

    // Stage 2 next state: outputs only change when the pipe moves.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        out_syn_d   = out_syn_q;
        if (advance_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = corr_data_s;
                out_err_d  = cls_err_s;
                out_syn_d  = s1_syn_q;
            end else begin
                out_data_d = out_data_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Saturating counters; a clear beats a same-cycle increment.
    always_comb begin
        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;
        if (cnt_clr) begin
            cnt_corr_d   = '0;
            cnt_uncorr_d = '0;
        end else if (out_fire_s) begin
            case (out_err_q)
                ERR_CORR: begin
                    if (cnt_corr_q != CNT_MAX) begin
                        cnt_corr_d = cnt_corr_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_corr_d = cnt_corr_q;
                    end
                end
                ERR_UNCORR: begin
                    if (cnt_uncorr_q != CNT_MAX) begin
                        cnt_uncorr_d = cnt_uncorr_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_uncorr_d = cnt_uncorr_q;
                    end
                end
                default: begin
                    cnt_corr_d   = cnt_corr_q;
                    cnt_uncorr_d = cnt_uncorr_q;
                end
            endcase
        end else begin
            cnt_corr_d = cnt_corr_q;
        end
    end

    // Sticky first-failure capture; a clear beats a same-cycle set.
    always_comb begin
        first_fail_d = first_fail_q;
        first_syn_d  = first_syn_q;
        if (cnt_clr) begin
            first_fail_d = 1'b0;
            first_syn_d  = '0;
        end else if (out_fire_s && (out_err_q == ERR_UNCORR) && !first_fail_q) begin
            first_fail_d = 1'b1;
            first_syn_d  = out_syn_q;
        end else begin
            first_fail_d = first_fail_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            s1_ce_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_err_q    <= ERR_NONE;
            out_syn_q    <= '0;
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
            first_fail_q <= 1'b0;
            first_syn_q  <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_syn_q     <= s1_syn_d;
            s1_par_q     <= s1_par_d;
            s1_ce_q      <= s1_ce_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_err_q    <= out_err_d;
            out_syn_q    <= out_syn_d;
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
            first_fail_q <= first_fail_d;
            first_syn_q  <= first_syn_d;
        end
    end

    assign in_ready   = advance_s;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;
    assign out_syn    = out_syn_q;
    assign cnt_corr   = cnt_corr_q;
    assign cnt_uncorr = cnt_uncorr_q;
    assign first_fail = first_fail_q;
    assign first_syn  = first_syn_q;

endmodule

// File: tb/tb_secded_pipe_corrector.sv
// -----------------------------------------------------------------------------
// tb_secded_pipe_corrector
// Directed bench for secded_pipe_corrector, DATA_W=32 (R=6), CNT_W=2 so that
// counter saturation is reachable in a few words.
// -----------------------------------------------------------------------------
module tb_secded_pipe_corrector;
    import secded_pkg::*;

    localparam int DW = 32;
    localparam int RB = 6;
    localparam int CW = 2;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [RB:0]   in_chk;
    logic          correct_en;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_err;
    logic [RB-1:0] out_syn;
    logic          cnt_clr;
    logic [CW-1:0] cnt_corr;
    logic [CW-1:0] cnt_uncorr;
    logic          first_fail;
    logic [RB-1:0] first_syn;

    int n_cmp;
    int n_bad;

    secded_pipe_corrector #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_chk     (in_chk),
        .correct_en (correct_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .out_syn    (out_syn),
        .cnt_clr    (cnt_clr),
        .cnt_corr   (cnt_corr),
        .cnt_uncorr (cnt_uncorr),
        .first_fail (first_fail),
        .first_syn  (first_syn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag, input int corr, input int uncorr,
                               input logic ff, input int fsyn);
        check_val({tag, ".cnt_corr"}, 64'(cnt_corr), 64'(corr));
        check_val({tag, ".cnt_uncorr"}, 64'(cnt_uncorr), 64'(uncorr));
        check_val({tag, ".first_fail"}, 64'(first_fail), 64'(ff));
        check_val({tag, ".first_syn"}, 64'(first_syn), 64'(fsyn));
    endtask

    // One word through an otherwise empty pipe; optional cnt_clr during its
    // output handshake. Returns one cycle after that handshake.
    task automatic run_one(input string tag, input logic [31:0] data, input logic [6:0] chk,
                           input logic ce, input logic [31:0] exp_data, input int exp_err,
                           input int exp_syn, input logic clr);
        in_valid   = 1'b1;
        in_data    = data;
        in_chk     = chk;
        correct_en = ce;
        #1;
        check_val({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        cyc();
        in_valid   = 1'b0;
        in_data    = 32'd0;
        in_chk     = 7'd0;
        correct_en = ~ce;
        #1;
        check_val({tag, ".lat1_valid"}, 64'(out_valid), 64'd0);
        cyc();
        check_val({tag, ".valid"}, 64'(out_valid), 64'd1);
        check_val({tag, ".data"}, 64'(out_data), 64'(exp_data));
        check_val({tag, ".err"}, 64'(out_err), 64'(exp_err));
        check_val({tag, ".syn"}, 64'(out_syn), 64'(exp_syn));
        cnt_clr = clr;
        cyc();
        cnt_clr = 1'b0;
        #1;
    endtask

    logic [7:0]  enc_v;
    logic [6:0]  c_dead;
    logic [31:0] bp_w [4];
    logic [31:0] exp_q [$];
    logic [31:0] exp_w;
    logic [31:0] held_data;
    logic [1:0]  held_err;
    logic [5:0]  held_syn;
    logic        stall_prev;
    int          idx;
    int          n_rx;

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 32'd0;
        in_chk     = 7'd0;
        correct_en = 1'b1;
        out_ready  = 1'b1;
        cnt_clr    = 1'b0;
        bp_w[0] = 32'h1111_1111;
        bp_w[1] = 32'h2222_2222;
        bp_w[2] = 32'h3333_3333;
        bp_w[3] = 32'hCAFE_F00D;

        // Reset state
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check_val("rst.out_valid", 64'(out_valid), 64'd0);
        check_val("rst.in_ready", 64'(in_ready), 64'd1);
        check_val("rst.out_data", 64'(out_data), 64'd0);
        check_val("rst.out_err", 64'(out_err), 64'd0);
        check_val("rst.out_syn", 64'(out_syn), 64'd0);
        check_stats("rst", 0, 0, 1'b0, 0);

        // Encoder reference values
        enc_v = enc(64'd1, DW);
        check_val("enc.one", 64'(enc_v), 64'h43);
        enc_v = enc(64'd0, DW);
        check_val("enc.zero", 64'(enc_v), 64'h00);
        check_val("pos.d0", 64'(data_pos(0)), 64'd3);

        // Clean stream
        cyc();
        run_one("clean0", 32'h0, 7'h00, 1'b1, 32'h0, 0, 0, 1'b0);
        enc_v  = enc({32'd0, 32'hDEAD_BEEF}, DW);
        c_dead = enc_v[6:0];
        run_one("cleanDB", 32'hDEAD_BEEF, c_dead, 1'b1, 32'hDEAD_BEEF, 0, 0, 1'b0);
        check_stats("clean", 0, 0, 1'b0, 0);

        // Single data error at position 3
        run_one("sec_ce1", 32'h0, 7'h43, 1'b1, 32'h1, 1, 3, 1'b0);
        check_val("sec_ce1.cnt_corr", 64'(cnt_corr), 64'd1);
        run_one("sec_ce0", 32'h0, 7'h43, 1'b0, 32'h0, 1, 3, 1'b0);
        check_val("sec_ce0.cnt_corr", 64'(cnt_corr), 64'd2);

        // Clear counters between groups
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        check_stats("clr1", 0, 0, 1'b0, 0);

        // Double error: data bits 0 and 1 (positions 3 and 5)
        run_one("ded", 32'h3, 7'h00, 1'b1, 32'h3, 2, 6, 1'b0);
        check_stats("ded", 0, 1, 1'b1, 6);
        // Odd flips pointing just past the last position (39) and far past (63)
        run_one("s39", 32'h0, 7'h67, 1'b1, 32'h0, 2, 39, 1'b0);
        check_stats("s39", 0, 2, 1'b1, 6);
        run_one("s63", 32'h0, 7'h7F, 1'b1, 32'h0, 2, 63, 1'b0);
        check_stats("s63", 0, 3, 1'b1, 6);
        run_one("ded2", 32'h3, 7'h00, 1'b1, 32'h3, 2, 6, 1'b0);
        check_val("ded2.uncorr_sat", 64'(cnt_uncorr), 64'd3);

        // Five corrected words: parity-only, check bit 0, last data position x2, pos 3
        run_one("ponly", 32'h0, 7'h40, 1'b1, 32'h0, 1, 0, 1'b0);
        run_one("chk0", 32'h0, 7'h01, 1'b1, 32'h0, 1, 1, 1'b0);
        run_one("d31_ce1", 32'h8000_0000, 7'h00, 1'b1, 32'h0, 1, 38, 1'b0);
        check_val("d31.cnt_corr", 64'(cnt_corr), 64'd3);
        run_one("d31_ce0", 32'h8000_0000, 7'h00, 1'b0, 32'h8000_0000, 1, 38, 1'b0);
        run_one("sec5", 32'h0, 7'h43, 1'b1, 32'h1, 1, 3, 1'b0);
        check_val("corr_sat", 64'(cnt_corr), 64'd3);

        // Clear coincident with counted handshakes
        run_one("clr_corr", 32'h0, 7'h43, 1'b1, 32'h1, 1, 3, 1'b1);
        check_stats("clr_corr", 0, 0, 1'b0, 0);
        run_one("clr_ded", 32'h3, 7'h00, 1'b1, 32'h3, 2, 6, 1'b1);
        check_stats("clr_ded", 0, 0, 1'b0, 0);
        run_one("post_clr", 32'h0, 7'h43, 1'b1, 32'h1, 1, 3, 1'b0);
        check_val("post_clr.cnt_corr", 64'(cnt_corr), 64'd1);

        // Backpressure: four back-to-back words, out_ready low for 3 cycles
        idx        = 0;
        n_rx       = 0;
        stall_prev = 1'b0;
        held_data  = 32'd0;
        held_err   = 2'd0;
        held_syn   = 6'd0;
        for (int c = 0; c < 14; c++) begin
            out_ready = !((c >= 3) && (c <= 5));
            if (idx < 4) begin
                in_valid   = 1'b1;
                in_data    = bp_w[idx];
                enc_v      = enc({32'd0, bp_w[idx]}, DW);
                in_chk     = enc_v[6:0];
                correct_en = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_prev) begin
                check_val("bp.hold_valid", 64'(out_valid), 64'd1);
                check_val("bp.hold_data", 64'(out_data), 64'(held_data));
                check_val("bp.hold_err", 64'(out_err), 64'(held_err));
                check_val("bp.hold_syn", 64'(out_syn), 64'(held_syn));
            end
            if (out_valid && !out_ready) begin
                check_val("bp.in_ready_low", 64'(in_ready), 64'd0);
            end
            if (out_valid && out_ready) begin
                n_rx++;
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    check_val("bp.data", 64'(out_data), 64'(exp_w));
                    check_val("bp.err", 64'(out_err), 64'd0);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(bp_w[idx]);
                idx++;
            end
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            held_err   = out_err;
            held_syn   = out_syn;
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_val("bp.sent", 64'(idx), 64'd4);
        check_val("bp.received", 64'(n_rx), 64'd4);
        check_val("bp.cnt_corr", 64'(cnt_corr), 64'd1);

        // Reset with two words in flight
        run_one("pre_rst", 32'h3, 7'h00, 1'b1, 32'h3, 2, 6, 1'b0);
        check_val("pre_rst.first_fail", 64'(first_fail), 64'd1);
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_data    = 32'h0;
        in_chk     = 7'h43;
        correct_en = 1'b1;
        cyc();
        in_data = 32'h3;
        in_chk  = 7'h00;
        cyc();
        check_val("inflight.valid", 64'(out_valid), 64'd1);
        rst      = 1'b1;
        in_valid = 1'b0;
        cyc();
        rst       = 1'b0;
        out_ready = 1'b1;
        check_val("mid_rst.out_valid", 64'(out_valid), 64'd0);
        check_val("mid_rst.in_ready", 64'(in_ready), 64'd1);
        check_val("mid_rst.out_data", 64'(out_data), 64'd0);
        check_stats("mid_rst", 0, 0, 1'b0, 0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            check_val("post_rst.no_stale", 64'(out_valid), 64'd0);
        end
        run_one("post_rst", 32'hDEAD_BEEF, c_dead, 1'b1, 32'hDEAD_BEEF, 0, 0, 1'b0);
        check_stats("post_rst", 0, 0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
